pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//   Parametrised elastic pipeline-stage register with per-stage valid/ready handshake,
//   flush and a DEPTH-entry skid buffer. Sits between any two CPU pipeline stages
//   (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying a packed control+data payload, and
//   absorbs downstream stalls without a combinational ready path back upstream.
// PARAMETERS
//   WIDTH   64   payload bits per entry (packed stage bundle)
//   DEPTH   2    buffer entries; power of two, >= 2
//   CNTW    $clog2(DEPTH)+1   occupancy counter width (derived, not overridden)
// PORTS
//   CLK        in   1      system clock, rising edge
//   nRST       in   1      asynchronous active-low reset
//   flush      in   1      discard all held and incoming entries (branch/jump squash)
//   in_valid   in   1      upstream presents in_data
//   in_ready   out  1      buffer can accept this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream consumes this cycle
//   out_data   out  WIDTH  oldest held entry
//   count      out  CNTW   current occupancy, 0..DEPTH
//   stall_cycles out 16    (PIPE_STATS_EN only) saturating count of out_valid && !out_ready
//   high_water   out CNTW  (PIPE_STATS_EN only) max occupancy since reset/flush
// BEHAVIOUR
//   - Reset (nRST=0, async): head=0, tail=0, count=0, out_valid=0, out_data=0,
//     in_ready=1; stats cleared. Storage array not reset.
//   - push = in_valid && in_ready; pop = out_valid && out_ready.
//   - Storage: circular buffer; push writes mem[tail], tail++ mod DEPTH;
//     pop advances head++ mod DEPTH. Pointers wrap naturally (log2 DEPTH bits).
//   - in_ready = (count != DEPTH), from registered count only (no out_ready path).
//   - out_valid = (count != 0); out_data = mem[head] when out_valid, else all-zero.
//   - Latency: entry pushed in cycle N is visible on out_data in cycle N+1 when empty.
//   - count next: +1 on push-only, -1 on pop-only, unchanged on push&&pop or neither.
//   - Full (count==DEPTH): in_ready=0; a same-cycle pop frees a slot only next cycle.
//   - Empty: pop impossible (out_valid=0); push&&pop cannot coincide on an empty buffer.
//   - flush (sync, highest priority): next cycle head=tail=0, count=0,
//     out_valid=0; any push or pop in the flush cycle is ignored.
//   - FIFO order strictly preserved; no entry duplicated or dropped except by flush.
//   - Reset asserted mid-transfer: all entries lost, outputs at reset values
//     immediately (async), resume accepting the first cycle after nRST deasserts.
// CONFIGURATION
//   PIPE_STATS_EN defined: stall_cycles increments each cycle out_valid && !out_ready,
//     saturates at 16'hFFFF; high_water tracks max(count); flush zeroes high_water
//     only (stall_cycles persists until reset).
//   PIPE_STATS_EN undefined: stall_cycles/high_water ports and logic absent;
//     datapath behaviour identical.
// TESTING
//   1 Reset: nRST=0 mid-run -> out_valid=0, count=0, in_ready=1, out_data=0 at once.
//   2 Pass-through, out_ready=1: push 32'hA0..A3 back-to-back -> each out one cycle
//     later in order, count stays <=1, in_ready never drops.
//   3 Fill, DEPTH=2: out_ready=0, push 64'h11, 64'h22 -> count=2, in_ready=0,
//     third in_valid ignored; out_ready=1 -> 64'h11 then 64'h22, then out_valid=0.
//   4 Wrap: DEPTH=4, 10 pushes with out_ready toggling 1/0 -> pointers wrap twice,
//     output sequence equals input sequence, count matches scoreboard each cycle.
//   5 Flush with simultaneous push and pop at count=2 -> next cycle count=0,
//     out_valid=0, pushed word never appears on out_data.
//   6 PIPE_STATS_EN: hold out_ready=0 with out_valid=1 for 5 cycles -> stall_cycles=5,
//     high_water=DEPTH; preload 16'hFFFE + 3 stalls -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular skid buffer with valid/ready
// handshake and synchronous flush. Define PIPE_STATS_EN to add stall/high-water counters.
module pipe_stage_buf #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNTW-1:0]  count
`ifdef PIPE_STATS_EN
   ,
   output logic [15:0]      stall_cycles,
   output logic [CNTW-1:0]  high_water
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [CNTW-1:0]  count_next;
   logic             push;
   logic             pop;

   // Handshake terms come from registered occupancy only, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (count != CNTW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[head] : '0;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNTW'(1);
      end else if (pop && !push) begin
         count_next = count - CNTW'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         count <= count_next;
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
         end
      end
   end

   // Payload storage is left unreset; out_data is masked while empty.
   always_ff @(posedge CLK) begin
      if (push && !flush) begin
         mem[tail] <= in_data;
      end
   end

`ifdef PIPE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

   // Tracking the next occupancy keeps high_water current with count.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         high_water <= '0;
      end else if (flush) begin
         high_water <= '0;
      end else if (count_next > high_water) begin
         high_water <= count_next;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=4 instances share stimulus and are
// checked every cycle against queue-based reference models plus literal checks.
module tb_pipe_stage_buf;

   localparam int W = 64;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;

   logic          ir2, ov2, ir4, ov4;
   logic [W-1:0]  od2, od4;
   logic [1:0]    cnt2;
   logic [2:0]    cnt4;
`ifdef PIPE_STATS_EN
   logic [15:0]   sc2, sc4;
   logic [1:0]    hw2;
   logic [2:0]    hw4;
`endif

   int tests = 0;
   int fails = 0;

   logic [W-1:0] q2[$];
   logic [W-1:0] q4[$];
   logic [W-1:0] got[$];
   int unsigned  stall2 = 0, stall4 = 0, hwm2 = 0, hwm4 = 0;

   always #5 CLK = ~CLK;

   pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) dut2 (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .count(cnt2)
`ifdef PIPE_STATS_EN
      , .stall_cycles(sc2), .high_water(hw2)
`endif
   );

   pipe_stage_buf #(.WIDTH(W), .DEPTH(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .count(cnt4)
`ifdef PIPE_STATS_EN
      , .stall_cycles(sc4), .high_water(hw4)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO queue per instance, updated on each clock edge.
   always @(posedge CLK or negedge nRST) begin : model
      bit p2, o2, p4, o4;
      if (!nRST) begin
         q2.delete(); q4.delete();
         stall2 = 0; stall4 = 0; hwm2 = 0; hwm4 = 0;
      end else begin
         if (q2.size() != 0 && !out_ready && stall2 != 65535) stall2++;
         if (q4.size() != 0 && !out_ready && stall4 != 65535) stall4++;
         if (flush) begin
            q2.delete(); q4.delete();
            hwm2 = 0; hwm4 = 0;
         end else begin
            p2 = in_valid && (q2.size() != 2);
            o2 = (q2.size() != 0) && out_ready;
            p4 = in_valid && (q4.size() != 4);
            o4 = (q4.size() != 0) && out_ready;
            if (o2) void'(q2.pop_front());
            if (p2) q2.push_back(in_data);
            if (o4) void'(q4.pop_front());
            if (p4) q4.push_back(in_data);
            if (q2.size() > hwm2) hwm2 = q2.size();
            if (q4.size() > hwm4) hwm4 = q4.size();
         end
      end
   end

   always @(negedge CLK) begin
      chk("m2_count", 64'(cnt2), 64'(q2.size()));
      chk("m2_out_valid", 64'(ov2), 64'(q2.size() != 0));
      chk("m2_in_ready", 64'(ir2), 64'(q2.size() != 2));
      chk("m2_out_data", od2, (q2.size() != 0) ? q2[0] : 64'h0);
      chk("m4_count", 64'(cnt4), 64'(q4.size()));
      chk("m4_out_valid", 64'(ov4), 64'(q4.size() != 0));
      chk("m4_in_ready", 64'(ir4), 64'(q4.size() != 4));
      chk("m4_out_data", od4, (q4.size() != 0) ? q4[0] : 64'h0);
`ifdef PIPE_STATS_EN
      chk("m2_stall", 64'(sc2), 64'(stall2));
      chk("m2_high_water", 64'(hw2), 64'(hwm2));
      chk("m4_stall", 64'(sc4), 64'(stall4));
      chk("m4_high_water", 64'(hw4), 64'(hwm4));
`endif
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int k;
      #1;
      chk("rst_out_valid", 64'(ov2), 64'h0);
      chk("rst_count", 64'(cnt2), 64'h0);
      chk("rst_in_ready", 64'(ir2), 64'h1);
      chk("rst_out_data", od2, 64'h0);
      step(); step();
      nRST = 1'b1;

      // Pass-through with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 64'hA0 + 64'(i);
         step();
         chk("pass_data", od2, 64'hA0 + 64'(i));
         chk("pass_count", 64'(cnt2), 64'h1);
         chk("pass_in_ready", 64'(ir2), 64'h1);
      end
      in_valid = 1'b0;
      step();
      chk("pass_drained", 64'(ov2), 64'h0);

      // Fill DEPTH=2, third push ignored, then drain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h11;
      step();
      in_data   = 64'h22;
      step();
      chk("fill_count", 64'(cnt2), 64'h2);
      chk("fill_in_ready", 64'(ir2), 64'h0);
      chk("fill_head", od2, 64'h11);
      in_data   = 64'h33;
      step();
      chk("fill_third_count", 64'(cnt2), 64'h2);
      chk("fill_third_head", od2, 64'h11);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("drain_second", od2, 64'h22);
      chk("drain_count", 64'(cnt2), 64'h1);
      step();
      chk("drain_empty", 64'(ov2), 64'h0);
      chk("drain_zero_data", od2, 64'h0);
      step();

      // Flush at count=2 with a simultaneous push and pop
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h44;
      step();
      in_data   = 64'h55;
      step();
      chk("pre_flush_count4", 64'(cnt4), 64'h2);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 64'h99;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      chk("flush_count2", 64'(cnt2), 64'h0);
      chk("flush_valid2", 64'(ov2), 64'h0);
      chk("flush_count4", 64'(cnt4), 64'h0);
      chk("flush_data4", od4, 64'h0);
      step();
      chk("flush_no_ghost", 64'(ov4), 64'h0);

      // Wrap DEPTH=4: ten accepted pushes with out_ready toggling
      k = 0;
      got.delete();
      for (int c = 0; c < 60 && (k < 10 || ov4); c++) begin
         in_valid  = (k < 10);
         in_data   = 64'h100 + 64'(k);
         out_ready = (k >= 10) ? 1'b1 : ((c % 2) == 0);
         if (ov4 && out_ready) got.push_back(od4);
         if (in_valid && ir4) k++;
         step();
      end
      in_valid = 1'b0;
      chk("wrap_pushes", 64'(k), 64'd10);
      chk("wrap_pops", 64'(got.size()), 64'd10);
      for (int i = 0; i < 10 && i < got.size(); i++)
         chk("wrap_order", got[i], 64'h100 + 64'(i));

      // Randomized traffic with occasional flush
      for (int c = 0; c < 600; c++) begin
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 3) != 0) ^ (c >= 300 && c < 400);
         in_data   = {$urandom, $urandom};
         step();
      end
      flush = 1'b0;

      // Asynchronous reset mid-transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h66;
      step();
      step();
      nRST = 1'b0;
      #1;
      chk("async_out_valid", 64'(ov2), 64'h0);
      chk("async_count", 64'(cnt2), 64'h0);
      chk("async_in_ready", 64'(ir2), 64'h1);
      chk("async_out_data", od2, 64'h0);
      chk("async_count4", 64'(cnt4), 64'h0);
      in_data = 64'h77;
      step(); step();
      nRST = 1'b1;
      step();
      chk("post_rst_count", 64'(cnt2), 64'h1);
      chk("post_rst_data", od2, 64'h77);
      in_valid = 1'b0;

`ifdef PIPE_STATS_EN
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h1;
      step();
      in_data   = 64'h2;
      step();
      in_valid  = 1'b0;
      repeat (4) step();
      chk("stats_stall5", 64'(sc2), 64'd5);
      chk("stats_hw", 64'(hw2), 64'd2);
      repeat (65530) step();
      chk("stats_sat", 64'(sc2), 64'hFFFF);
      repeat (3) step();
      chk("stats_sat_hold", 64'(sc2), 64'hFFFF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("stats_flush_hw", 64'(hw2), 64'd0);
      chk("stats_flush_keep", 64'(sc2), 64'hFFFF);
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
